// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, downstream hold and a saturating bubble counter.
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_RegWrite,
    input  logic              id_RegDst,
    input  logic              id_ALUSrc,
    input  logic              id_Branch,
    input  logic              id_MemWrite,
    input  logic              id_MemRead,
    input  logic              id_MemToReg,
    input  logic [1:0]        id_ALUOp,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [5:0]        id_funct,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic              ex_RegWrite,
    output logic              ex_RegDst,
    output logic              ex_ALUSrc,
    output logic              ex_Branch,
    output logic              ex_MemWrite,
    output logic              ex_MemRead,
    output logic              ex_MemToReg,
    output logic [1:0]        ex_ALUOp,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [5:0]        ex_funct,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic              stall_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int unsigned REG_W      = 5;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned CTRL_W     = 9;
    localparam int unsigned C_REGWRITE = 8;
    localparam int unsigned C_REGDST   = 7;
    localparam int unsigned C_ALUSRC   = 6;
    localparam int unsigned C_BRANCH   = 5;
    localparam int unsigned C_MEMWRITE = 4;
    localparam int unsigned C_MEMREAD  = 3;
    localparam int unsigned C_MEMTOREG = 2;

    logic [CTRL_W-1:0]  id_ctrl;
    logic [CTRL_W-1:0]  ctrl_q,   ctrl_d;
    logic               valid_q,  valid_d;
    logic [REG_W-1:0]   rs_q,     rs_d;
    logic [REG_W-1:0]   rt_q,     rt_d;
    logic [REG_W-1:0]   rd_q,     rd_d;
    logic [FUNCT_W-1:0] funct_q,  funct_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic [DATA_W-1:0]  rdata2_q, rdata2_d;
    logic [DATA_W-1:0]  imm_q,    imm_d;
    logic [DATA_W-1:0]  pc4_q,    pc4_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               uses_rt;
    logic               hazard;

    assign id_ctrl = {id_RegWrite, id_RegDst, id_ALUSrc, id_Branch, id_MemWrite,
                      id_MemRead, id_MemToReg, id_ALUOp};

    // rt is a source for R-type, branches and stores; a load in EX blocks any real source match
    assign uses_rt   = ~id_ALUSrc | id_MemWrite;
    assign hazard    = valid_q & ctrl_q[C_MEMREAD] & id_valid & (rt_q != '0)
                     & ((rt_q == id_rs) | (uses_rt & (rt_q == id_rt)));
    assign stall_out = (hazard | ex_hold) & ~flush;

    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        funct_d  = funct_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        pc4_d    = pc4_q;
        cnt_d    = cnt_q;
        // Data fields follow ID on every non-hold edge; only control/valid differ by rule
        if (flush || !ex_hold) begin
            rs_d     = id_rs;
            rt_d     = id_rt;
            rd_d     = id_rd;
            funct_d  = id_funct;
            rdata1_d = id_rdata1;
            rdata2_d = id_rdata2;
            imm_d    = id_imm;
            pc4_d    = id_pc4;
        end
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (ex_hold) begin
            valid_d = valid_q;
        end else if (hazard) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d = id_valid;
            ctrl_d  = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            funct_q  <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc4_q    <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            funct_q  <= funct_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            pc4_q    <= pc4_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_RegWrite = ctrl_q[C_REGWRITE];
    assign ex_RegDst   = ctrl_q[C_REGDST];
    assign ex_ALUSrc   = ctrl_q[C_ALUSRC];
    assign ex_Branch   = ctrl_q[C_BRANCH];
    assign ex_MemWrite = ctrl_q[C_MEMWRITE];
    assign ex_MemRead  = ctrl_q[C_MEMREAD];
    assign ex_MemToReg = ctrl_q[C_MEMTOREG];
    assign ex_ALUOp    = ctrl_q[1:0];
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;
    assign ex_funct    = funct_q;
    assign ex_rdata1   = rdata1_q;
    assign ex_rdata2   = rdata2_q;
    assign ex_imm      = imm_q;
    assign ex_pc4      = pc4_q;
    assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use bubbles, flush/hold collisions,
// mid-stall reset and counter saturation on a narrow second instance.
module tb_id_ex_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid, id_RegWrite, id_RegDst, id_ALUSrc, id_Branch;
    logic        id_MemWrite, id_MemRead, id_MemToReg;
    logic [1:0]  id_ALUOp;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic        flush, ex_hold;

    logic        ex_valid, ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch;
    logic        ex_MemWrite, ex_MemRead, ex_MemToReg;
    logic [1:0]  ex_ALUOp;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_funct;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic        stall_out;
    logic [15:0] bubble_cnt;

    logic        s_valid, s_RegWrite, s_RegDst, s_ALUSrc, s_Branch;
    logic        s_MemWrite, s_MemRead, s_MemToReg;
    logic [1:0]  s_ALUOp;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [5:0]  s_funct;
    logic [7:0]  s_rdata1, s_rdata2, s_imm, s_pc4;
    logic        s_stall;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    id_ex_stage dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_RegWrite(id_RegWrite), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc),
        .id_Branch(id_Branch), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
        .id_MemToReg(id_MemToReg), .id_ALUOp(id_ALUOp), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_funct(id_funct), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm(id_imm), .id_pc4(id_pc4), .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_RegDst(ex_RegDst),
        .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch), .ex_MemWrite(ex_MemWrite),
        .ex_MemRead(ex_MemRead), .ex_MemToReg(ex_MemToReg), .ex_ALUOp(ex_ALUOp),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .stall_out(stall_out), .bubble_cnt(bubble_cnt)
    );

    // Narrow instance so counter saturation is reachable in a short run
    id_ex_stage #(.DATA_W(8), .CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_RegWrite(id_RegWrite), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc),
        .id_Branch(id_Branch), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
        .id_MemToReg(id_MemToReg), .id_ALUOp(id_ALUOp), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_funct(id_funct), .id_rdata1(id_rdata1[7:0]),
        .id_rdata2(id_rdata2[7:0]), .id_imm(id_imm[7:0]), .id_pc4(id_pc4[7:0]),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(s_valid), .ex_RegWrite(s_RegWrite), .ex_RegDst(s_RegDst),
        .ex_ALUSrc(s_ALUSrc), .ex_Branch(s_Branch), .ex_MemWrite(s_MemWrite),
        .ex_MemRead(s_MemRead), .ex_MemToReg(s_MemToReg), .ex_ALUOp(s_ALUOp),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_funct(s_funct),
        .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm), .ex_pc4(s_pc4),
        .stall_out(s_stall), .bubble_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] c, input logic [1:0] op,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [5:0] fn, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] im, input logic [31:0] pc);
        id_valid = v;
        {id_RegWrite, id_RegDst, id_ALUSrc, id_Branch, id_MemWrite, id_MemRead, id_MemToReg} = c;
        id_ALUOp = op;
        id_rs = rs; id_rt = rt; id_rd = rd; id_funct = fn;
        id_rdata1 = r1; id_rdata2 = r2; id_imm = im; id_pc4 = pc;
    endtask

    task automatic id_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] r1, input logic [31:0] r2);
        set_id(1'b1, 7'b1100000, 2'b10, rs, rt, rd, 6'h20, r1, r2, 32'h0, 32'h100);
    endtask

    task automatic id_lw(input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, 7'b1010011, 2'b00, rs, rt, 5'd0, 6'h0, 32'h11, 32'h22, 32'h4, 32'h40);
    endtask

    task automatic id_addi(input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, 7'b1010000, 2'b00, rs, rt, 5'd0, 6'h0, 32'h33, 32'h44, 32'h9, 32'h80);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        set_id(1'b1, 7'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               6'($urandom), $urandom, $urandom, $urandom, $urandom);
        tick();
        tick();
        chk("rst_ctrl", {ex_valid, ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_Branch, ex_MemWrite,
                         ex_MemRead, ex_MemToReg, ex_ALUOp, ex_rs, ex_rt, ex_rd, ex_funct}, '0);
        chk("rst_data", {ex_rdata1, ex_rdata2, ex_imm, ex_pc4}, '0);
        chk("rst_cnt", bubble_cnt, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_small", {s_valid, s_RegWrite, s_RegDst, s_ALUSrc, s_Branch, s_MemWrite,
                          s_MemRead, s_MemToReg, s_ALUOp, s_rs, s_rt, s_rd, s_funct,
                          s_rdata1, s_rdata2, s_imm, s_pc4, s_stall, s_cnt}, '0);
        reset = 1'b0;

        // Plain capture
        id_add(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        tick();
        chk("cap_ctrl", {ex_valid, ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_MemRead, ex_ALUOp},
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10});
        chk("cap_fields", {ex_rd, ex_rdata1, ex_rdata2}, {5'd3, 32'd5, 32'd7});

        // Load-use on rs
        id_lw(5'd1, 5'd8);
        #1 chk("lu_pre_stall", stall_out, 0);
        tick();
        id_add(5'd8, 5'd2, 5'd3, 32'd1, 32'd2);
        #1 chk("lu_stall", stall_out, 1);
        tick();
        chk("lu_bubble", {ex_valid, ex_RegWrite, ex_rs}, {1'b0, 1'b0, 5'd8});
        chk("lu_cnt", bubble_cnt, 1);
        chk("lu_stall_gone", stall_out, 0);
        tick();
        chk("lu_add_in_ex", {ex_valid, ex_RegWrite, ex_rs, ex_funct}, {1'b1, 1'b1, 5'd8, 6'h20});

        // Load to $0 never stalls
        id_lw(5'd1, 5'd0);
        tick();
        id_add(5'd0, 5'd5, 5'd6, 32'd0, 32'd0);
        #1 chk("zero_stall", stall_out, 0);
        tick();
        chk("zero_cap", {ex_valid, ex_rs, bubble_cnt}, {1'b1, 5'd0, 16'd1});

        // addi reads only rs, so a matching rt is not a hazard
        id_lw(5'd1, 5'd9);
        tick();
        id_addi(5'd4, 5'd9);
        #1 chk("addi_stall", stall_out, 0);
        tick();
        chk("addi_cap", {ex_valid, ex_ALUSrc, ex_rt, bubble_cnt}, {1'b1, 1'b1, 5'd9, 16'd1});

        // Flush wins over hazard
        id_lw(5'd1, 5'd10);
        tick();
        id_add(5'd10, 5'd2, 5'd3, 32'd0, 32'd0);
        flush = 1'b1;
        #1 chk("fl_stall", stall_out, 0);
        tick();
        flush = 1'b0;
        chk("fl_ex", {ex_valid, ex_RegWrite, ex_MemRead, ex_rs, bubble_cnt},
            {1'b0, 1'b0, 1'b0, 5'd10, 16'd1});

        // Hold freezes EX across a pending hazard; one bubble after release
        id_lw(5'd1, 5'd11);
        tick();
        id_add(5'd11, 5'd2, 5'd3, 32'd0, 32'd0);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_stall", stall_out, 1);
            tick();
            chk("hold_frozen", {ex_valid, ex_MemRead, ex_rt, ex_rs, bubble_cnt},
                {1'b1, 1'b1, 5'd11, 5'd1, 16'd1});
        end
        ex_hold = 1'b0;
        #1 chk("hold_rel_stall", stall_out, 1);
        tick();
        chk("hold_bubble", {ex_valid, ex_RegWrite, bubble_cnt}, {1'b0, 1'b0, 16'd2});
        tick();
        chk("hold_add", {ex_valid, ex_RegWrite, ex_rs}, {1'b1, 1'b1, 5'd11});

        // Invalid slot keeps data but drops control
        set_id(1'b0, 7'b1100110, 2'b10, 5'd1, 5'd2, 5'd3, 6'h20, 32'd9, 32'd9, 32'd9, 32'd9);
        tick();
        chk("inv_slot", {ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUOp, ex_rd},
            {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd3});

        // Reset during a stall
        id_lw(5'd1, 5'd12);
        tick();
        id_add(5'd12, 5'd2, 5'd3, 32'd0, 32'd0);
        #1 chk("rs_stall_pre", stall_out, 1);
        reset = 1'b1;
        tick();
        chk("rs_mid", {ex_valid, ex_MemRead, ex_rt, bubble_cnt, stall_out}, '0);
        reset = 1'b0;

        // Back-to-back load-use: one bubble every two edges
        id_lw(5'd8, 5'd8);
        for (int i = 0; i < 40; i++) tick();
        chk("sat_main", bubble_cnt, 20);
        chk("sat_small", s_cnt, 4'hF);
        tick();
        tick();
        chk("sat_main_more", bubble_cnt, 21);
        chk("sat_small_hold", s_cnt, 4'hF);
        chk("sat_small_ex", {s_valid, s_RegWrite, s_RegDst, s_ALUSrc, s_Branch, s_MemWrite,
                             s_MemRead, s_MemToReg, s_ALUOp, s_rs, s_rt, s_rd, s_funct,
                             s_rdata1, s_rdata2, s_imm, s_pc4, s_stall},
            {1'b0, 9'd0, 5'd8, 5'd8, 5'd0, 6'd0, 8'h11, 8'h22, 8'h04, 8'h40, 1'b0});
        chk("sat_main_ex", {ex_valid, ex_MemToReg, ex_Branch, ex_MemWrite, ex_imm, ex_pc4},
            {1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h40});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register and load-use hazard unit between instruction decode and execute in the pipelined MIPS core. Captures the control bits produced by the main control unit, together with the decoded operand fields, on each clock edge. Detects load-use hazards against the instruction currently in EX, then stalls upstream and inserts a bubble. Also applies branch flushes and downstream holds, and counts inserted bubbles for performance reporting.

## Interface
Parameters:
- DATA_W, 32, width of register-file operands, immediate and PC+4
- CNT_W, 16, width of the bubble counter

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_RegWrite, id_RegDst, id_ALUSrc, id_Branch, id_MemWrite, id_MemRead, id_MemToReg  in  1 each  decode control bits
- id_ALUOp  in  2  decode ALU operation class
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_funct  in  6  function field
- id_rdata1, id_rdata2, id_imm, id_pc4  in  DATA_W each  operand A, operand B, sign-extended immediate, PC+4
- flush  in  1  branch taken in a later stage; discard ID and EX contents
- ex_hold  in  1  downstream cannot accept; freeze EX
- ex_valid  out  1  EX holds a real instruction
- ex_RegWrite … ex_MemToReg, ex_ALUOp, ex_rs, ex_rt, ex_rd, ex_funct, ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  same widths as id_ counterparts  registered copies
- stall_out  out  1  combinational; PC and IF/ID must hold this cycle
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles inserted

## Operation
- Rule selection: exactly one rule applies per edge, in priority order: reset > flush > ex_hold > load-use bubble > capture.
- Reset: every output register is cleared to 0, including ex_valid, all control bits, ex_ALUOp, all data fields and bubble_cnt.
- Flush: ex_valid, all ex_ control bits and ex_ALUOp are cleared to 0; data fields are loaded from the id_ inputs; bubble_cnt is unchanged.
- ex_hold (no flush): all EX registers and bubble_cnt keep their values.
- uses_rt = id_ALUSrc==0 OR id_MemWrite==1, covering R-type, beq, bne and sw.
- hazard = ex_valid & ex_MemRead & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
- Load-use bubble (hazard, no flush, no hold):
  - EX is loaded as for a flush: control bits and ALUOp cleared, ex_valid=0, data fields taken from id_ inputs.
  - bubble_cnt increments by 1, saturating at all-ones with no wrap.
- Capture: every ex_ field is loaded from its id_ counterpart; ex_valid = id_valid.
  - When id_valid=0, all ex_ control bits are forced to 0, so an invalid slot never writes registers or memory.
- stall_out = (hazard & ~flush) | (ex_hold & ~flush).
  - A flush never stalls, because upstream discards the wrong-path instruction itself.

## Timing
- Latency: 1 cycle from id_ inputs to ex_ outputs.
- stall_out is combinational from the current EX registers and the id_ inputs, valid in the same cycle.
- A load-use hazard produces exactly one bubble. On the following cycle, EX holds no load, so hazard=0 and the held ID instruction is captured.
- flush and hazard in the same cycle: the flush rule applies; no bubble is counted and stall_out=0.
- ex_hold and hazard in the same cycle: EX is frozen, stall_out=1, no bubble is counted. The hazard is re-evaluated after the hold releases.
- reset asserted mid-stall: all outputs are 0 on the next edge; stall_out falls because ex_valid=0.

## Test plan
- Reset: drive id_valid=1 with random fields and reset=1 for 2 edges -> all ex_ outputs 0, bubble_cnt=0, stall_out=0.
- Plain capture: add with rs=1, rt=2, rd=3, rdata1=5, rdata2=7 -> next cycle ex_RegWrite=1, ex_RegDst=1, ex_ALUOp=2'b10, ex_rd=3, ex_rdata1=5, ex_valid=1.
- Load-use: lw with rt=8 in EX, then add with rs=8 in ID:
  - same cycle: stall_out=1;
  - next edge: ex_valid=0, ex_RegWrite=0, bubble_cnt=1;
  - following edge: the add is in EX.
- Load to $0: lw with rt=0 followed by add with rs=0 -> stall_out=0, no bubble, bubble_cnt unchanged.
- addi after lw: lw rt=9, then addi with rt=9 and rs=4 (uses_rt=0) -> stall_out=0; the addi is captured directly.
- Collisions:
  - hazard with flush=1 in the same cycle -> stall_out=0, ex_valid=0, bubble_cnt unchanged;
  - hazard with ex_hold=1 for 3 cycles -> EX frozen, stall_out=1 throughout, exactly 1 bubble after the release;
  - preload bubble_cnt to 16'hFFFF, then force another bubble -> bubble_cnt stays 16'hFFFF.
